// File: rtl/sd_tag_word_counter.sv
// Streaming keyword counter: waits for BEGIN_TAG, counts whole-word keyword
// matches until END_TAG, then freezes with done set.
module sd_tag_word_counter #(
    parameter int unsigned          KEY_MAX   = 8,
    parameter int unsigned          TAG_LEN   = 8,
    parameter logic [8*TAG_LEN-1:0] BEGIN_TAG = "DLAB_TAG",
    parameter logic [8*TAG_LEN-1:0] END_TAG   = "DLAB_END",
    parameter int unsigned          COUNT_W   = 7,
    parameter bit                   CASE_FOLD = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [7:0]                   in_byte,
    input  logic [8*KEY_MAX-1:0]         key,
    input  logic [$clog2(KEY_MAX+1)-1:0] key_len,
    output logic                         tag_found,
    output logic                         done,
    output logic [COUNT_W-1:0]           match_count,
    output logic                         overflow
);

    localparam int unsigned LW = $clog2(KEY_MAX+1);

    typedef enum logic [1:0] {
        S_SEEK,
        S_SCAN,
        S_DONE
    } state_t;

    state_t               state;
    logic [8*TAG_LEN-1:0] tag_sr;
    logic [8*TAG_LEN-1:0] tag_sr_nxt;
    logic [LW-1:0]        idx;
    logic                 word_ok;

    logic                 begin_hit;
    logic                 end_hit;
    logic                 is_delim;
    logic [7:0]           key_char;
    logic                 char_eq;
    logic                 word_hit;

    function automatic logic [7:0] fold(input logic [7:0] c);
        if (CASE_FOLD && (c >= 8'h41) && (c <= 8'h5A))
            return c | 8'h20;
        return c;
    endfunction

    // Hits are judged on the window including the byte being consumed now.
    always_comb begin
        tag_sr_nxt = {tag_sr[8*TAG_LEN-9:0], in_byte};
        begin_hit  = (tag_sr_nxt == BEGIN_TAG);
        end_hit    = (tag_sr_nxt == END_TAG);
    end

    always_comb begin
        is_delim = 1'b0;
        case (in_byte)
            8'h20, 8'h0A, 8'h0D, 8'h09, 8'h2C, 8'h2E: is_delim = 1'b1;
            default:                                   is_delim = 1'b0;
        endcase
    end

    // Keyword is right-aligned: char idx lives at byte position key_len-1-idx.
    always_comb begin
        key_char = '0;
        for (int unsigned i = 0; i < KEY_MAX; i++) begin
            if (i + 32'(idx) + 32'd1 == 32'(key_len))
                key_char = key[8*i +: 8];
        end
    end

    always_comb begin
        char_eq  = (fold(in_byte) == fold(key_char));
        word_hit = word_ok && (idx == key_len) && (key_len != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_SEEK;
            tag_sr      <= '0;
            idx         <= '0;
            word_ok     <= 1'b1;
            tag_found   <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            state       <= S_SEEK;
            tag_sr      <= '0;
            idx         <= '0;
            word_ok     <= 1'b1;
            tag_found   <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (in_valid) begin
            tag_sr <= tag_sr_nxt;
            case (state)
                S_SEEK: begin
                    if (begin_hit) begin
                        state     <= S_SCAN;
                        tag_found <= 1'b1;
                        idx       <= '0;
                        word_ok   <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (end_hit) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (is_delim) begin
                        if (word_hit) begin
                            if (match_count == '1)
                                overflow <= 1'b1;
                            else
                                match_count <= match_count + 1'b1;
                        end
                        idx     <= '0;
                        word_ok <= 1'b1;
                    end else if (word_ok && (idx < key_len) && char_eq) begin
                        idx <= idx + 1'b1;
                    end else begin
                        word_ok <= 1'b0;
                    end
                end
                S_DONE: begin
                end
                default: state <= S_SEEK;
            endcase
        end
    end

endmodule

// File: doc/sd_tag_word_counter.md
Name: sd_tag_word_counter

Overview:
- Streaming word-match counter placed between the SD-sector SRAM read-out FSM and the LCD formatter.
- Consumes one text byte per valid strobe and waits for a BEGIN tag.
- After the tag, counts whole-word occurrences of a run-time keyword until an END tag, then freezes and flags done.
- Parametrised successor of the fixed "DLAB_TAG … the … DLAB_END" scanner: adds programmable keyword and length, parametrised tags, selectable case folding, a larger delimiter set, and a saturating counter.

Parameters:
- KEY_MAX, 8: maximum keyword length in bytes.
- BEGIN_TAG, "DLAB_TAG": start marker string. Case-sensitive.
- END_TAG, "DLAB_END": stop marker string. Case-sensitive.
- TAG_LEN, 8: byte length of both tags.
- COUNT_W, 7: match counter width.
- CASE_FOLD, 1: 1 = keyword compare ignores ASCII case (A-Z folded to a-z); 0 = exact compare.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous restart pulse. Returns the block to SEEK and zeroes the count.
- in_valid, in, 1: in_byte is valid this cycle.
- in_byte, in, 8: text byte.
- key, in, 8*KEY_MAX: keyword, right-aligned string literal. Char i (0 = first) sits at key[8*(key_len-1-i) +: 8].
- key_len, in, $clog2(KEY_MAX+1): keyword length, 1..KEY_MAX. Must be stable outside SEEK.
- tag_found, out, 1: BEGIN tag has been seen.
- done, out, 1: END tag has been seen; count is frozen.
- match_count, out, COUNT_W: number of whole-word matches.
- overflow, out, 1: sticky; set when a match arrived while the count was at its maximum.

Behaviour:
- Reset (async, reset_n=0): state=SEEK; tag_found=0, done=0, match_count=0, overflow=0; tag shift register cleared to 0x00 bytes; idx=0, word_ok=1.
- Per-byte processing happens only on cycles with in_valid=1. All outputs are registered and update on the clock edge that consumes the byte, so latency is 1 cycle.
- Tag detection:
  - An 8*TAG_LEN shift register holds the last TAG_LEN valid bytes, newest in the LSBs.
  - A tag hits when the register, after shifting in the current byte, equals the tag.
  - This handles overlapping prefixes such as "DDLAB_TAG" correctly.
- States:
  - SEEK: shift bytes in. On a BEGIN_TAG hit: go to SCAN, tag_found<=1, idx<=0, word_ok<=0. The tag's own last byte is not a delimiter, so the first word requires a preceding delimiter.
  - SCAN: word matcher runs (below). On an END_TAG hit: go to DONE, done<=1. The byte that completes END_TAG is not counted, and any partial word is discarded.
  - DONE: ignore all input. Only clear or reset leaves this state.
- Delimiters: space 0x20, LF 0x0A, CR 0x0D, TAB 0x09, ',' 0x2C, '.' 0x2E.
- Word matcher, in SCAN, on each valid byte b:
  - If b is a delimiter:
    - If word_ok=1 and idx==key_len, increment match_count.
    - Then set idx<=0, word_ok<=1.
  - Else if word_ok=1, idx<key_len, and fold(b)==fold(key char idx): idx<=idx+1.
  - Else: word_ok<=0. The rest of the word is ignored until the next delimiter.
  - fold() is applied only when CASE_FOLD=1.
  - Result: "the" matches; "then", "bathe" and "th" do not.
- Counter saturates at 2^COUNT_W-1. A further match leaves the count unchanged and sets overflow<=1 (sticky until clear or reset).
- END tag check and word-match update are evaluated on the same byte; the END hit takes priority.
- clear=1: same effect as reset, but synchronous. It overrides in_valid in the same cycle, and that byte is dropped.
- key_len=0: no match is ever counted; tag detection is still functional.
- in_valid gaps of any length are allowed, and state holds across them.

Test Plan:
- Stream "xx DLAB_TAG the cat The,THE.then DLAB_END the " with key="the", key_len=3, CASE_FOLD=1 -> tag_found=1; match_count=3, counting "the", "The," and "THE."; done=1; count stays 3 after the END tag.
- Same stream with CASE_FOLD=0 -> match_count=1.
- "DDLAB_TAG\nthe\n" then "DLAB_END" -> tag_found=1 after the byte 'G'; match_count=1; done=1.
- Stream " the the" with no BEGIN tag, then reset_n=0 asserted for 3 ns mid-stream between clock edges -> count stays 0 before reset; outputs are 0 immediately, without waiting for a clock edge.
- COUNT_W=3 with 9 matches of " a" (key="a", key_len=1) after the tag -> match_count=7, overflow=1.
- clear asserted in the same cycle as the final 'D' of END_TAG -> done=0, match_count=0, state=SEEK; the 'D' is dropped.
